// File: rtl/dp_pkg.sv
// Shared opcode encodings, flag bit positions and decode helpers for the
// two-stage ALU datapath.
package dp_pkg;

   localparam logic [7:0] OP_ADD = 8'h00;
   localparam logic [7:0] OP_SUB = 8'h01;
   localparam logic [7:0] OP_AND = 8'h02;
   localparam logic [7:0] OP_OR  = 8'h03;
   localparam logic [7:0] OP_XOR = 8'h04;
   localparam logic [7:0] OP_NOT = 8'h05;
   localparam logic [7:0] OP_SHL = 8'h06;
   localparam logic [7:0] OP_SHR = 8'h07;
   localparam logic [7:0] OP_SAR = 8'h08;
   localparam logic [7:0] OP_CMP = 8'h09;
   localparam logic [7:0] OP_MOV = 8'h0A;

   localparam int unsigned FLG_C = 0;
   localparam int unsigned FLG_Z = 1;
   localparam int unsigned FLG_N = 2;
   localparam int unsigned FLG_V = 3;

   // Codes above OP_MOV are undefined: result 0, no writeback, flags kept.
   function automatic logic op_defined(input logic [7:0] op);
      return (op <= OP_MOV);
   endfunction

   function automatic logic op_writes(input logic [7:0] op);
      return (op <= OP_MOV) && (op != OP_CMP);
   endfunction

endpackage

// File: rtl/dp_regfile.sv
// General register file: two asynchronous read ports, one synchronous write
// port, synchronous active-high clear of every entry.
module dp_regfile #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_raddr_a,
   input  logic [ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] r_mem [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_datapath_pipe.sv
// Two-stage (OP capture, EX/writeback) register-file ALU datapath with a
// valid/ready result stream. Define DP_FORWARD_EN for the EX-to-OP bypass.
module alu_datapath_pipe
   import dp_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        opcode,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic              we,
   input  logic              imm_sel,
   input  logic [DATA_W-1:0] immediate,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        flags
);

   localparam int unsigned SH_W = $clog2(DATA_W);
   localparam int unsigned MSB  = DATA_W - 1;

   logic              r_op_valid;
   logic [7:0]        r_op_code;
   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic [ADDR_W-1:0] r_op_rd;
   logic              r_op_we;

   logic [DATA_W-1:0] r_out;
   logic              r_out_valid;
   logic [3:0]        r_flags;

   logic              w_adv;
   logic              w_hazard;
   logic              w_accept;
   logic              w_ex_wr;
   logic [DATA_W-1:0] w_rf_a;
   logic [DATA_W-1:0] w_rf_b;
   logic [DATA_W-1:0] w_src_a;
   logic [DATA_W-1:0] w_src_b;
   logic [DATA_W-1:0] w_res;
   logic [DATA_W:0]   w_ext;
   logic [SH_W-1:0]   w_sh;
   logic              w_c;
   logic              w_v;

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv && !w_hazard && !reset;
   assign w_accept = in_valid && in_ready;
   assign w_ex_wr  = w_adv && r_op_valid && r_op_we && op_writes(r_op_code);

`ifdef DP_FORWARD_EN
   assign w_hazard = 1'b0;
   assign w_src_a  = (w_ex_wr && (r_op_rd == rs1)) ? w_res : w_rf_a;
   assign w_src_b  = (w_ex_wr && (r_op_rd == rs2)) ? w_res : w_rf_b;
`else
   // Hold a consumer of the in-flight destination until its writeback lands.
   assign w_hazard = r_op_valid && r_op_we && op_writes(r_op_code) &&
                     ((rs1 == r_op_rd) || (!imm_sel && (rs2 == r_op_rd)));
   assign w_src_a  = w_rf_a;
   assign w_src_b  = w_rf_b;
`endif

   dp_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_raddr_a (rs1),
      .i_raddr_b (rs2),
      .o_rdata_a (w_rf_a),
      .o_rdata_b (w_rf_b),
      .i_we      (w_ex_wr),
      .i_waddr   (r_op_rd),
      .i_wdata   (w_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_valid <= 1'b0;
         r_op_code  <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_rd    <= '0;
         r_op_we    <= 1'b0;
      end else if (w_accept) begin
         r_op_valid <= 1'b1;
         r_op_code  <= opcode;
         r_op_a     <= w_src_a;
         r_op_b     <= imm_sel ? immediate : w_src_b;
         r_op_rd    <= rd;
         r_op_we    <= we;
      end else if (w_adv) begin
         r_op_valid <= 1'b0;
      end
   end

   assign w_sh = r_op_b[SH_W-1:0];

   // Shifts run on a one-bit-wider vector so the last bit out lands in w_ext.
   always_comb begin
      w_res = '0;
      w_ext = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (r_op_code)
         OP_ADD: begin
            w_ext = {1'b0, r_op_a} + {1'b0, r_op_b};
            w_res = w_ext[DATA_W-1:0];
            w_c   = w_ext[DATA_W];
            w_v   = (r_op_a[MSB] == r_op_b[MSB]) && (w_res[MSB] != r_op_a[MSB]);
         end
         OP_SUB, OP_CMP: begin
            w_ext = {1'b0, r_op_a} - {1'b0, r_op_b};
            w_res = w_ext[DATA_W-1:0];
            w_c   = !w_ext[DATA_W];
            w_v   = (r_op_a[MSB] != r_op_b[MSB]) && (w_res[MSB] != r_op_a[MSB]);
         end
         OP_AND: w_res = r_op_a & r_op_b;
         OP_OR:  w_res = r_op_a | r_op_b;
         OP_XOR: w_res = r_op_a ^ r_op_b;
         OP_NOT: w_res = ~r_op_a;
         OP_SHL: begin
            w_ext = {1'b0, r_op_a} << w_sh;
            w_res = w_ext[DATA_W-1:0];
            w_c   = w_ext[DATA_W];
         end
         OP_SHR: begin
            w_ext = {r_op_a, 1'b0} >> w_sh;
            w_res = w_ext[DATA_W:1];
            w_c   = w_ext[0];
         end
         OP_SAR: begin
            w_ext = $signed({r_op_a, 1'b0}) >>> w_sh;
            w_res = w_ext[DATA_W:1];
            w_c   = w_ext[0];
         end
         OP_MOV: w_res = r_op_b;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_flags     <= '0;
      end else if (w_adv) begin
         r_out_valid <= r_op_valid;
         if (r_op_valid) begin
            r_out <= w_res;
            if (op_defined(r_op_code)) begin
               r_flags[FLG_C] <= w_c;
               r_flags[FLG_Z] <= (w_res == '0);
               r_flags[FLG_N] <= w_res[MSB];
               r_flags[FLG_V] <= w_v;
            end
         end
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign flags     = r_flags;

endmodule

// File: doc/alu_datapath_pipe.md
# alu_datapath_pipe

Parametrised, two-stage pipelined successor to the single-cycle register-bank/ALU datapath. It holds a NREGS x DATA_W register file with two read ports and an optional immediate on operand B. Results are written back to the register file and presented on a valid/ready output stream, and a registered flag word is kept. It sits between the instruction decoder/controller and the result consumer, such as the memory interface or an I/O register.

## Interface
- DATA_W, 16, datapath and register width (>= 4)
- NREGS, 16, number of general registers (power of two, >= 2)
- ADDR_W, $clog2(NREGS), register index width (derived)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted when in_valid && in_ready
- opcode  in  8  ALU operation (codes in package)
- rs1, rs2  in  ADDR_W  source register indices (A, B)
- rd  in  ADDR_W  destination index
- we  in  1  write result to rd
- imm_sel  in  1  1: operand B = immediate, 0: B = reg[rs2]
- immediate  in  DATA_W  immediate operand
- out  out  DATA_W  registered result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- flags  out  4  registered {V,N,Z,C}

## Operation
- Advance enable `adv = !out_valid || out_ready`. `in_ready = adv && !hazard_stall && !reset`.
- OP stage, on accept: capture opA, opB, opcode, rd, and we into the OP registers, and set op_valid. If adv && !accept, clear op_valid.
- EX stage: the ALU is combinational on the OP registers. On adv && op_valid:
  - out <= result, out_valid <= 1.
  - flags update.
  - If we is set and the opcode writes, reg[rd] <= result at the same edge.
- On adv && !op_valid: out_valid <= 0, and out holds its value.
- Opcodes, all DATA_W wide with wrap-around arithmetic:
  - ADD 0x00: A+B, C = carry out, V = signed overflow.
  - SUB 0x01: A-B, C = no-borrow (A >= B unsigned), V = signed overflow.
  - AND 0x02, OR 0x03, XOR 0x04, NOT 0x05 (~A): C = 0, V = 0.
  - SHL 0x06 / SHR 0x07 / SAR 0x08: shift A by B[$clog2(DATA_W)-1:0]. C = last bit shifted out (0 if the amount is 0). V = 0.
  - CMP 0x09: computes SUB and sets flags; never writes rd; out = difference.
  - MOV 0x0A: B; C = 0, V = 0.
  - Any other code: result 0, no register write, flags unchanged, out_valid still asserted.
- Z = (result == 0). N = result[DATA_W-1]. Neither is updated for undefined opcodes.
- Forwarding (DP_FORWARD_EN): the OP capture of rs1/rs2 takes the live EX result when EX writes that index at the same edge. The immediate path is never forwarded.
- Register-file read and write to the same index at the same edge: the read returns the new value when forwarding is compiled in.

## Timing
- Latency is 2 cycles from accept to out_valid, with no back-pressure. Throughput is 1 per cycle.
- Back-pressure: when out_valid && !out_ready, the whole pipe freezes. OP registers, out, flags, and the register file stay unchanged, and in_ready = 0.
- Reset, effective at the edge where reset is high:
  - All registers are set to 0, including op_valid, out, out_valid, and flags.
  - An in-flight instruction is discarded with no writeback.
  - in_ready = 0 while reset is high.
  - First accept is possible in the cycle after reset deasserts.
- out and flags are stable while out_valid && !out_ready.

## Configuration
- DP_FORWARD_EN defined: EX-to-OP bypass is present, and hazard_stall = 0 always.
- DP_FORWARD_EN undefined: no bypass.
  - hazard_stall = op_valid && op_we && op_writes && ((rs1 == op_rd) || (!imm_sel && rs2 == op_rd)).
  - This inserts one bubble per dependent back-to-back instruction.

## Structure
- Package dp_pkg holds:
  - opcode localparams (OP_ADD..OP_MOV)
  - flag bit indices (FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3)
  - the writes-rd function (false for CMP and undefined codes).
- Sub-module dp_regfile, parametrised by DATA_W and NREGS:
  - 2 asynchronous read ports, 1 synchronous write port, synchronous reset to 0.
  - The ALU and pipeline control stay in alu_datapath_pipe.

## Test plan
- Reset, then MOV imm 0x1234 to r3 (we=1), then ADD r3+r3 to r4 back-to-back.
  - Forwarding in: out=0x1234 at cycle 2, then 0x2468 at cycle 3, with no stall.
  - Forwarding out: one cycle with in_ready=0, then 0x2468.
- ADD 0xFFFF + 0x0001 (DATA_W=16): out=0x0000, flags C=1, Z=1, N=0, V=0. ADD 0x7FFF+1: out=0x8000, V=1, N=1, C=0.
- SUB 0x0003-0x0005: out=0xFFFE, C=0, N=1. CMP r,r with equal values: Z=1, C=1, destination register unchanged.
- SAR 0x8001 by 1: out=0xC000, C=1. SHL by 0: out=A, C=0. Undefined opcode 0xFF: out=0, flags unchanged, rd unchanged.
- Hold out_ready=0 for 3 cycles with 3 instructions queued: in_ready=0, out/flags/register file frozen. Releasing gives results in order with none lost or duplicated.
- Assert reset with 2 instructions in flight: out_valid=0, out=0, flags=0, all registers read 0, and the targeted rd is not written.
